// File: rtl/psram_mem_ctrl.sv
// Asynchronous-mode PSRAM / cellular RAM controller for the 16-bit core.
// One single-word access in flight, fixed wait states, one-cycle ready pulse.
module psram_mem_ctrl #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned READ_WAIT  = 4,
  parameter int unsigned WRITE_WAIT = 4,
  parameter int unsigned RECOVERY   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [23:0]       addr,
  input  logic [15:0]       wdata,
  input  logic [1:0]        be,
  output logic [15:0]       rdata,
  output logic              ready,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_dq_o,
  input  logic [15:0]       ram_dq_i,
  output logic              ram_dq_oe,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              ram_lb_n,
  output logic              ram_ub_n
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned RD_N     = (READ_WAIT  == 0) ? 1 : READ_WAIT;
  localparam int unsigned WR_N     = (WRITE_WAIT == 0) ? 1 : WRITE_WAIT;
  localparam int unsigned REC_LOAD = (RECOVERY   == 0) ? 0 : RECOVERY - 1;
  localparam bit          HAS_REC  = (RECOVERY != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_DONE, S_RECOVER
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [1:0]       be_q;
  logic [15:0]      wdata_q;

  logic             cur_we;
  logic [1:0]       cur_be;
  logic [15:0]      cur_wdata;
  logic             ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d, dq_oe_d, ready_d, busy_d;
  logic [15:0]      dq_o_d;

  // Upper address bits beyond the RAM width are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (req) state_next = S_SETUP;
      S_SETUP:   state_next = S_ACCESS;
      S_ACCESS:  if (cnt == '0) state_next = S_DONE;
      S_DONE:    state_next = HAS_REC ? S_RECOVER : S_IDLE;
      S_RECOVER: if (cnt == '0) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // The request fields are latched on the accept edge, so use the live inputs there.
  always_comb begin
    cur_we    = (state == S_IDLE) ? we    : we_q;
    cur_be    = (state == S_IDLE) ? be    : be_q;
    cur_wdata = (state == S_IDLE) ? wdata : wdata_q;
  end

  // Values the pad registers take for the cycle entered at the next edge.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    dq_o_d  = ram_dq_o;
    ready_d = 1'b0;
    busy_d  = (state_next != S_IDLE);
    case (state_next)
      S_SETUP, S_ACCESS: begin
        ce_n_d = 1'b0;
        if (cur_we) begin
          we_n_d  = (state_next == S_SETUP);
          dq_oe_d = 1'b1;
          dq_o_d  = cur_wdata;
          lb_n_d  = ~cur_be[0];
          ub_n_d  = ~cur_be[1];
        end else begin
          oe_n_d = 1'b0;
          lb_n_d = 1'b0;
          ub_n_d = 1'b0;
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        if (cur_we) begin
          dq_oe_d = 1'b1;
          dq_o_d  = cur_wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      be_q     <= 2'b00;
      wdata_q  <= 16'h0000;
      ram_addr <= '0;
      cnt      <= '0;
      rdata    <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          we_q     <= we;
          be_q     <= be;
          wdata_q  <= wdata;
          ram_addr <= addr[ADDR_W-1:0];
        end
        S_SETUP: cnt <= we_q ? CNT_W'(WR_N - 1) : CNT_W'(RD_N - 1);
        S_ACCESS: begin
          if (cnt == '0) begin
            cnt <= CNT_W'(REC_LOAD);
            if (!we_q) rdata <= ram_dq_i;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RECOVER: if (cnt != '0) cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_ce_n  <= 1'b1;
      ram_oe_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      ram_lb_n  <= 1'b1;
      ram_ub_n  <= 1'b1;
      ram_dq_oe <= 1'b0;
      ram_dq_o  <= 16'h0000;
      ready     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ram_ce_n  <= ce_n_d;
      ram_oe_n  <= oe_n_d;
      ram_we_n  <= we_n_d;
      ram_lb_n  <= lb_n_d;
      ram_ub_n  <= ub_n_d;
      ram_dq_oe <= dq_oe_d;
      ram_dq_o  <= dq_o_d;
      ready     <= ready_d;
      busy      <= busy_d;
    end
  end

endmodule
